// File: rtl/dffrs_ctrl_pkg.sv
// Shared encodings for the DFFRS bank controller: op codes, FSM states, common constants.
package dffrs_ctrl_pkg;

    localparam int OP_W = 2;
    localparam int PULSE_CYC_MIN = 1;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SET  = 2'b01,
        OP_CLR  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_DRIVE   = 2'b01,
        ST_RECOVER = 2'b10,
        ST_DONE    = 2'b11
    } state_e;

    function automatic logic op_is_strobe(input op_e op);
        return (op == OP_SET) || (op == OP_CLR);
    endfunction

endpackage

// File: rtl/dffrs_bank_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the tie-break pointer moves only when a grant is acknowledged.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] gnt_ack,
    output logic [1:0] grant
);

    logic prio_r;

    // tie-break pointer: 0 lets req[0] win a tie, 1 lets req[1] win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= 1'b0;
        end else if (gnt_ack[0]) begin
            prio_r <= 1'b1;
        end else if (gnt_ack[1]) begin
            prio_r <= 1'b0;
        end else begin
            prio_r <= prio_r;
        end
    end

    // grant decode from current requests and pointer
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_r ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dffrs_bank_ctrl.sv
// Sequences two requesters' LOAD / SET / CLR operations onto a DFFRS register bank.
// All bank and handshake outputs come straight from flops so S and R can never glitch together.
module dffrs_bank_ctrl
    import dffrs_ctrl_pkg::*;
#(
    parameter int NREG      = 8,
    parameter int WIDTH     = 8,
    parameter int AW        = $clog2(NREG),
    parameter int PULSE_CYC = 2
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              req0,
    input  logic              req1,
    input  logic [1:0]        op0,
    input  logic [1:0]        op1,
    input  logic [AW-1:0]     addr0,
    input  logic [AW-1:0]     addr1,
    input  logic [WIDTH-1:0]  data0,
    input  logic [WIDTH-1:0]  data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              err,
    output logic [NREG-1:0]   bank_sel,
    output logic [WIDTH-1:0]  bank_d,
    output logic              bank_ld,
    output logic [WIDTH-1:0]  bank_s,
    output logic [WIDTH-1:0]  bank_r
);

    localparam int CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam int AWP   = AW + 1;
    localparam logic [AW:0]     NREG_L  = AWP'(NREG);
    localparam logic [NREG-1:0] SEL_ONE = {{(NREG-1){1'b0}}, 1'b1};

    state_e             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    op_e                op_r, op_nxt_s;
    logic [WIDTH-1:0]   data_r, data_nxt_s;
    logic               who_r, who_nxt_s;

    logic               gnt0_r, gnt1_r, err_r, ld_r;
    logic [NREG-1:0]    sel_r;
    logic [WIDTH-1:0]   d_r, s_r, r_r;
    logic               gnt0_nxt_s, gnt1_nxt_s, err_nxt_s, ld_nxt_s;
    logic [NREG-1:0]    sel_nxt_s;
    logic [WIDTH-1:0]   d_nxt_s, s_nxt_s, r_nxt_s;

    logic [1:0]         grant_s;
    op_e                win_op_s;
    logic [AW-1:0]      win_addr_s;
    logic [WIDTH-1:0]   win_data_s;
    logic               win_bad_s;

    rr_arb2 u_arb (
        .clk     (CLK),
        .rst_n   (RSTn),
        .req     ({req1, req0}),
        .gnt_ack ({gnt1_r, gnt0_r}),
        .grant   (grant_s)
    );

    // winner's request fields and error classification
    always_comb begin
        win_op_s   = op_e'(grant_s[1] ? op1 : op0);
        win_addr_s = grant_s[1] ? addr1 : addr0;
        win_data_s = grant_s[1] ? data1 : data0;
        win_bad_s  = (win_op_s == OP_RSVD) || ({1'b0, win_addr_s} >= NREG_L);
    end

    // next state and next value of every registered output
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        op_nxt_s    = op_r;
        data_nxt_s  = data_r;
        who_nxt_s   = who_r;
        gnt0_nxt_s  = 1'b0;
        gnt1_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        ld_nxt_s    = 1'b0;
        sel_nxt_s   = '0;
        d_nxt_s     = '0;
        s_nxt_s     = '0;
        r_nxt_s     = '0;
        case (state_r)
            ST_IDLE: begin
                if (grant_s != 2'b00) begin
                    who_nxt_s  = grant_s[1];
                    op_nxt_s   = win_op_s;
                    data_nxt_s = win_data_s;
                    if (win_bad_s) begin
                        state_nxt_s = ST_DONE;
                        err_nxt_s   = 1'b1;
                        gnt0_nxt_s  = ~grant_s[1];
                        gnt1_nxt_s  = grant_s[1];
                    end else begin
                        state_nxt_s = ST_DRIVE;
                        cnt_nxt_s   = CNT_W'(PULSE_CYC - 1);
                        sel_nxt_s   = SEL_ONE << win_addr_s;
                        case (win_op_s)
                            OP_LOAD: begin
                                d_nxt_s  = win_data_s;
                                ld_nxt_s = 1'b1;
                            end
                            OP_SET:  s_nxt_s = win_data_s;
                            OP_CLR:  r_nxt_s = win_data_s;
                            default: ld_nxt_s = 1'b0;
                        endcase
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                sel_nxt_s = sel_r;
                if (!op_is_strobe(op_r) || (cnt_r == '0)) begin
                    state_nxt_s = ST_RECOVER;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                    s_nxt_s   = (op_r == OP_SET) ? data_r : '0;
                    r_nxt_s   = (op_r == OP_CLR) ? data_r : '0;
                end
            end
            ST_RECOVER: begin
                state_nxt_s = ST_DONE;
                gnt0_nxt_s  = ~who_r;
                gnt1_nxt_s  = who_r;
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM, counter, latched request and output registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            op_r    <= OP_LOAD;
            data_r  <= '0;
            who_r   <= 1'b0;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            err_r   <= 1'b0;
            ld_r    <= 1'b0;
            sel_r   <= '0;
            d_r     <= '0;
            s_r     <= '0;
            r_r     <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            op_r    <= op_nxt_s;
            data_r  <= data_nxt_s;
            who_r   <= who_nxt_s;
            gnt0_r  <= gnt0_nxt_s;
            gnt1_r  <= gnt1_nxt_s;
            err_r   <= err_nxt_s;
            ld_r    <= ld_nxt_s;
            sel_r   <= sel_nxt_s;
            d_r     <= d_nxt_s;
            s_r     <= s_nxt_s;
            r_r     <= r_nxt_s;
        end
    end

    assign gnt0     = gnt0_r;
    assign gnt1     = gnt1_r;
    assign err      = err_r;
    assign bank_sel = sel_r;
    assign bank_d   = d_r;
    assign bank_ld  = ld_r;
    assign bank_s   = s_r;
    assign bank_r   = r_r;

endmodule
